// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the decode/ID-EX pipeline controller: FSM encodings,
// instruction field positions, bubble fields and the per-cycle control word.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int FUNCT_HI = 15;
  localparam int FUNCT_LO = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 8;
  localparam int RS_HI    = 7;
  localparam int RS_LO    = 4;
  localparam int RT_HI    = 3;
  localparam int RT_LO    = 0;

  // What the ID/EX register loads when idex_flush is asserted
  localparam logic [3:0] BUBBLE_FUNCT = 4'h0;
  localparam logic [3:0] BUBBLE_RS    = 4'h0;
  localparam logic [3:0] BUBBLE_RT    = 4'h0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic issue;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{pc_en:1'b0, ifid_en:1'b0, ifid_flush:1'b1,
                                    idex_en:1'b0, idex_flush:1'b1, issue:1'b0};
  localparam ctrl_t CTRL_HOLD   = '{pc_en:1'b0, ifid_en:1'b0, ifid_flush:1'b0,
                                    idex_en:1'b0, idex_flush:1'b0, issue:1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_en:1'b1, ifid_en:1'b1, ifid_flush:1'b1,
                                    idex_en:1'b1, idex_flush:1'b1, issue:1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{pc_en:1'b0, ifid_en:1'b0, ifid_flush:1'b0,
                                    idex_en:1'b1, idex_flush:1'b1, issue:1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_en:1'b1, ifid_en:1'b1, ifid_flush:1'b0,
                                    idex_en:1'b1, idex_flush:1'b0, issue:1'b0};

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, cleared on
// writeback and set on issue (set wins on a same-register collision).
module reg_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int R = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_en,
  input  logic [R-1:0]      clr_addr,
  input  logic              set_en,
  input  logic [R-1:0]      set_addr,
  input  logic [R-1:0]      rd_a,
  input  logic [R-1:0]      rd_b,
  input  logic [R-1:0]      rd_w,
  output logic              hit_a,
  output logic              hit_b,
  output logic              hit_w,
  output logic [(2**R)-1:0] pending
);

  logic [(2**R)-1:0] pend_q, pend_nx;

  always_comb begin
    pend_nx = pend_q;
    if (clr_en) pend_nx[clr_addr] = 1'b0;
    if (set_en) pend_nx[set_addr] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_nx;
  end

  // Reads see only the registered vector: no writeback bypass.
  assign hit_a   = pend_q[rd_a];
  assign hit_b   = pend_q[rd_b];
  assign hit_w   = pend_q[rd_w];
  assign pending = pend_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage pipeline controller: RAW/WAW stall against the scoreboard,
// multicycle-EX hold, taken-branch flush, and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int R         = 4,
  parameter int F         = 4,
  parameter int FLUSH_CYC = 1,
  parameter int CW        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [R-1:0]      id_rs_i,
  input  logic [R-1:0]      id_rt_i,
  input  logic [R-1:0]      id_rd_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_wr_i,
  input  logic              wb_we_i,
  input  logic [R-1:0]      wb_wa_i,
  input  logic              ex_busy_i,
  input  logic              br_taken_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              ifid_flush_o,
  output logic              idex_en_o,
  output logic              idex_flush_o,
  output logic              issue_o,
  output logic [(2**R)-1:0] pending_o,
  output logic [1:0]        state_o,
  output logic [CW-1:0]     stall_cnt_o
);

  if (FLUSH_CYC < 0 || FLUSH_CYC > 7 || F < 1 || R < 1 || CW < 1) begin : g_bad_param
    $error("pipe_hazard_ctrl: parameter out of range");
  end

  localparam logic [2:0] FLUSH_LD = (FLUSH_CYC > 0) ? 3'(FLUSH_CYC - 1) : 3'd0;

  logic [1:0]    state_q, state_nx;
  logic [2:0]    fcnt_q, fcnt_nx;
  logic [CW-1:0] stall_cnt_q;
  logic          hit_a, hit_b, hit_w, hazard, stall_inc;
  ctrl_t         ctrl;

  reg_scoreboard #(.R(R)) u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_en   (wb_we_i),
    .clr_addr (wb_wa_i),
    .set_en   (ctrl.issue & id_wr_i),
    .set_addr (id_rd_i),
    .rd_a     (id_rs_i),
    .rd_b     (id_rt_i),
    .rd_w     (id_rd_i),
    .hit_a    (hit_a),
    .hit_b    (hit_b),
    .hit_w    (hit_w),
    .pending  (pending_o)
  );

  assign hazard    = id_valid_i & ((id_use_rs_i & hit_a) | (id_use_rt_i & hit_b) | (id_wr_i & hit_w));
  assign stall_inc = (ex_busy_i | hazard) & ~rst_i;

  // RUN and STALL share one priority chain; STALL only records why we held.
  always_comb begin
    ctrl     = CTRL_RUN;
    state_nx = ST_RUN;
    fcnt_nx  = fcnt_q;
    if (rst_i) begin
      ctrl = CTRL_RESET;
    end else if (state_q == ST_FLUSH) begin
      ctrl = CTRL_FLUSH;
      if (fcnt_q == 3'd0) state_nx = ST_RUN;
      else begin
        state_nx = ST_FLUSH;
        fcnt_nx  = fcnt_q - 3'd1;
      end
    end else if (ex_busy_i) begin
      ctrl     = CTRL_HOLD;
      state_nx = ST_STALL;
    end else if (br_taken_i) begin
      ctrl = CTRL_FLUSH;
      if (FLUSH_CYC > 0) begin
        state_nx = ST_FLUSH;
        fcnt_nx  = FLUSH_LD;
      end
    end else if (hazard) begin
      ctrl     = CTRL_BUBBLE;
      state_nx = ST_STALL;
    end else begin
      ctrl.issue = id_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_nx;
      fcnt_q  <= fcnt_nx;
      if (stall_inc && stall_cnt_q != {CW{1'b1}}) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign pc_en_o      = ctrl.pc_en;
  assign ifid_en_o    = ctrl.ifid_en;
  assign ifid_flush_o = ctrl.ifid_flush;
  assign idex_en_o    = ctrl.idex_en;
  assign idex_flush_o = ctrl.idex_flush;
  assign issue_o      = ctrl.issue;
  assign state_o      = state_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
